// File: rtl/fetch_common_cells.sv
// Common cells for the frontend instruction queue: a flushable FIFO with an
// optional fall-through mode, a leading/trailing-zero counter, and a sink for
// signals that are deliberately left unused.

// Sink for signals that are intentionally not consumed.
module unread (
  input logic d_i
);
endmodule

// Leading/trailing-zero counter. When in_i is zero, cnt_o is 0 and empty_o is 1.
module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  // Scan so that the bit nearest the counted end is assigned last and wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_o   = '0;
    empty_o = ~|in_i;
    if (MODE == 1'b0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// Circular-buffer FIFO with synchronous flush and optional fall-through.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH:0]   DEPTH_CNT = (ADDR_DEPTH + 1)'(DEPTH);
  localparam logic [ADDR_DEPTH-1:0] LAST_PTR  = ADDR_DEPTH'(DEPTH - 1);

  logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
  logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
  logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
  logic                  mem_we;
  logic                  stored_empty;
  logic                  bypass;
  logic                  push_ok;
  logic                  pop_ok;
  dtype                  mem_q [DEPTH];

  unread i_unread_testmode (.d_i(testmode_i));

  assign stored_empty = (status_cnt_q == '0);
  // An empty fall-through FIFO presents the incoming word directly.
  assign bypass       = FALL_THROUGH && stored_empty && push_i;

  // Status and head-of-queue outputs.
  always_comb begin
    full_o  = (status_cnt_q == DEPTH_CNT);
    empty_o = stored_empty && !bypass;
    usage_o = status_cnt_q[ADDR_DEPTH-1:0];
    data_o  = bypass ? data_i : mem_q[read_ptr_q];
  end

  // Pointer and count update; flush overrides any push or pop.
  always_comb begin
    read_ptr_d   = read_ptr_q;
    write_ptr_d  = write_ptr_q;
    status_cnt_d = status_cnt_q;
    mem_we       = 1'b0;
    push_ok      = push_i && !full_o;
    pop_ok       = pop_i && !empty_o;
    if (flush_i) begin
      read_ptr_d   = '0;
      write_ptr_d  = '0;
      status_cnt_d = '0;
    end else if (!(bypass && pop_ok)) begin
      if (push_ok) begin
        mem_we       = 1'b1;
        write_ptr_d  = (write_ptr_q == LAST_PTR) ? '0 : write_ptr_q + 1'b1;
        status_cnt_d = status_cnt_d + 1'b1;
      end
      if (pop_ok) begin
        read_ptr_d   = (read_ptr_q == LAST_PTR) ? '0 : read_ptr_q + 1'b1;
        status_cnt_d = status_cnt_d - 1'b1;
      end
    end
  end

  // State and storage registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      read_ptr_q   <= '0;
      write_ptr_q  <= '0;
      status_cnt_q <= '0;
      // NOTE: storage is reset on purpose so data_o reads 0 out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      read_ptr_q   <= read_ptr_d;
      write_ptr_q  <= write_ptr_d;
      status_cnt_q <= status_cnt_d;
      if (mem_we) mem_q[write_ptr_q] <= data_i;
    end
  end

endmodule

// Wrapper exposing one FIFO and a trailing/leading-zero counter pair.
module fetch_common_cells #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned LZC_WIDTH    = 4,
  localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LZC_CNT_W   = (LZC_WIDTH > 1) ? $clog2(LZC_WIDTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i,
  input  logic [LZC_WIDTH-1:0]  lzc_in_i,
  output logic [LZC_CNT_W-1:0]  tz_cnt_o,
  output logic                  tz_empty_o,
  output logic [LZC_CNT_W-1:0]  lz_cnt_o,
  output logic                  lz_empty_o
);

  fifo_v3 #(
    .FALL_THROUGH (FALL_THROUGH),
    .DATA_WIDTH   (DATA_WIDTH),
    .DEPTH        (DEPTH)
  ) i_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .testmode_i (testmode_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .usage_o    (usage_o),
    .data_i     (data_i),
    .push_i     (push_i),
    .data_o     (data_o),
    .pop_i      (pop_i)
  );

  lzc #(.WIDTH(LZC_WIDTH), .MODE(1'b0)) i_tzc (
    .in_i    (lzc_in_i),
    .cnt_o   (tz_cnt_o),
    .empty_o (tz_empty_o)
  );

  lzc #(.WIDTH(LZC_WIDTH), .MODE(1'b1)) i_lzc (
    .in_i    (lzc_in_i),
    .cnt_o   (lz_cnt_o),
    .empty_o (lz_empty_o)
  );

endmodule

// File: tb/tb_fetch_common_cells.sv
// Scoreboard bench for fetch_common_cells: a standard and a fall-through
// instance run the same stimulus against queue-based reference models.
module tb_fetch_common_cells;

  typedef logic [7:0] byte_q_t [$];

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_i, push_i, pop_i;
  logic [7:0] data_i;
  logic [3:0] lzc_in;

  logic       full0, empty0, full1, empty1;
  logic [1:0] usage0, usage1;
  logic [7:0] data0, data1;
  logic [1:0] tz_cnt, lz_cnt, tz_cnt1, lz_cnt1;
  logic       tz_empty, lz_empty, tz_empty1, lz_empty1;

  int checks = 0;
  int passed = 0;

  byte_q_t mq0, mq1;   // model contents
  byte_q_t sb0, sb1;   // expected pop data

  always #5 clk = ~clk;

  fetch_common_cells #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4), .LZC_WIDTH(4)) u_std (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .testmode_i(1'b0),
    .full_o(full0), .empty_o(empty0), .usage_o(usage0),
    .data_i(data_i), .push_i(push_i), .data_o(data0), .pop_i(pop_i),
    .lzc_in_i(lzc_in), .tz_cnt_o(tz_cnt), .tz_empty_o(tz_empty),
    .lz_cnt_o(lz_cnt), .lz_empty_o(lz_empty)
  );

  fetch_common_cells #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4), .LZC_WIDTH(4)) u_ft (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .testmode_i(1'b0),
    .full_o(full1), .empty_o(empty1), .usage_o(usage1),
    .data_i(data_i), .push_i(push_i), .data_o(data1), .pop_i(pop_i),
    .lzc_in_i(lzc_in), .tz_cnt_o(tz_cnt1), .tz_empty_o(tz_empty1),
    .lz_cnt_o(lz_cnt1), .lz_empty_o(lz_empty1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference FIFO: a queue of at most 4 entries, evaluated just before the edge.
  task automatic model_step(input bit ft, inout byte_q_t q, input string tag,
                            input logic full_a, input logic empty_a, input logic [1:0] usage_a,
                            output bit pop_ok, output logic [7:0] pop_data);
    int cnt;
    bit exp_full, exp_empty, push_ok;
    cnt       = q.size();
    exp_full  = (cnt == 4);
    exp_empty = (cnt == 0) && !(ft && push_i);
    check({tag, "_full"},  full_a,  exp_full);
    check({tag, "_empty"}, empty_a, exp_empty);
    check({tag, "_usage"}, usage_a, cnt % 4);
    pop_ok   = 1'b0;
    pop_data = '0;
    if (flush_i) begin
      q.delete();
    end else begin
      push_ok = push_i && !exp_full;
      pop_ok  = pop_i && !exp_empty;
      if (pop_ok) pop_data = (cnt == 0) ? data_i : q[0];
      if (pop_ok && cnt > 0) void'(q.pop_front());
      if (push_ok && !(pop_ok && cnt == 0)) q.push_back(data_i);
    end
  endtask

  task automatic step(input bit push, input bit pop, input bit flush, input logic [7:0] d);
    bit ok;
    logic [7:0] pd;
    @(posedge clk);
    #1;
    push_i  = push;
    pop_i   = pop;
    flush_i = flush;
    data_i  = d;
    #1;
    model_step(1'b0, mq0, "std", full0, empty0, usage0, ok, pd);
    if (ok) sb0.push_back(pd);
    model_step(1'b1, mq1, "ft", full1, empty1, usage1, ok, pd);
    if (ok) sb1.push_back(pd);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_std_full"},  full0,  1'b0);
    check({tag, "_std_empty"}, empty0, 1'b1);
    check({tag, "_std_usage"}, usage0, 2'd0);
    check({tag, "_std_data"},  data0,  8'h00);
    check({tag, "_ft_full"},   full1,  1'b0);
    check({tag, "_ft_empty"},  empty1, 1'b1);
    check({tag, "_ft_usage"},  usage1, 2'd0);
    check({tag, "_ft_data"},   data1,  8'h00);
  endtask

  // Monitors: whenever a DUT presents a pop it will accept, compare against the scoreboard.
  always @(negedge clk) begin
    if (!rst && !flush_i && pop_i && !empty0) begin
      if (sb0.size() == 0) begin
        checks++;
        $display("FAIL std_pop_unexpected: got %0h, expected no pop (t=%0t)", data0, $time);
      end else begin
        check("std_pop_data", data0, sb0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !flush_i && pop_i && !empty1) begin
      if (sb1.size() == 0) begin
        checks++;
        $display("FAIL ft_pop_unexpected: got %0h, expected no pop (t=%0t)", data1, $time);
      end else begin
        check("ft_pop_data", data1, sb1.pop_front());
      end
    end
  end

  function automatic int tz_model(input int x);
    int n = 0;
    if (x == 0) return 0;
    while (x % 2 == 0) begin
      x = x / 2;
      n++;
    end
    return n;
  endfunction

  function automatic int lz_model(input int x);
    int h = -1;
    if (x == 0) return 0;
    while (x > 0) begin
      x = x / 2;
      h++;
    end
    return 3 - h;
  endfunction

  initial begin
    rst = 1'b1; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; data_i = '0; lzc_in = '0;
    #2;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill, overflow attempt, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, 8'(i * 8'h11));
    step(1'b1, 1'b0, 1'b0, 8'h55);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);

    // Full with simultaneous push and pop: pop wins, push dropped.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, 8'(i * 8'h11));
    step(1'b1, 1'b1, 1'b0, 8'h66);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Flush together with a push on a two-entry FIFO.
    step(1'b1, 1'b0, 1'b0, 8'h01);
    step(1'b1, 1'b0, 1'b0, 8'h02);
    step(1'b1, 1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Fall-through bypass on empty with push and pop together.
    step(1'b1, 1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-cycle on a partly filled FIFO.
    step(1'b1, 1'b0, 1'b0, 8'h0B);
    step(1'b1, 1'b0, 1'b0, 8'h0C);
    @(posedge clk);
    #1;
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    mq0.delete(); mq1.delete(); sb0.delete(); sb1.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
           $urandom_range(0, 99) < 3, 8'($urandom));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("std_sb_drained", sb0.size(), 0);
    check("ft_sb_drained", sb1.size(), 0);

    // Zero counters over every 4-bit input.
    for (int v = 0; v < 16; v++) begin
      lzc_in = 4'(v);
      #1;
      check($sformatf("tz_cnt_%0h", v), tz_cnt, tz_model(v));
      check($sformatf("lz_cnt_%0h", v), lz_cnt, lz_model(v));
      check($sformatf("tz_empty_%0h", v), tz_empty, v == 0);
      check($sformatf("lz_empty_%0h", v), lz_empty, v == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
